// File: rtl/decoder_pkg.sv
// Shared definitions for the registered binary-to-one-hot decoder.
// Optional feature macro: DECODER_ONEHOT_CHECK_EN (see decoder_2to4.sv).
package decoder_pkg;

    // Default select width: 2 select bits give a 4-bit one-hot output.
    localparam int DEC_IN_W_DEFAULT = 2;

    // One-hot output width for a given select width.
    function automatic int dec_out_w(input int in_w);
        return 2 ** in_w;
    endfunction

    // One-hot vector for the default configuration. Bit 0 is the leftmost bit
    // and corresponds to select value 0.
    typedef logic [0:3] dec_onehot_t;

endpackage

// File: rtl/decoder_onehot_comb.sv
// Purely combinational binary-to-one-hot decode. i_sel[0] is the MSB.
// o_onehot[k] is high only when the unsigned value of i_sel equals k.
module decoder_onehot_comb
    import decoder_pkg::*;
#(
    parameter  int IN_W  = DEC_IN_W_DEFAULT,
    localparam int OUT_W = dec_out_w(IN_W)
) (
    input  logic [0:IN_W-1]  i_sel,
    output logic [0:OUT_W-1] o_onehot
);

    // One equality comparator per output bit; at most one can match.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign o_onehot[gi] = (i_sel == IN_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_2to4.sv
// Registered binary-to-one-hot decoder with valid flag.
//  - IN_W select bits (legal 1..6) -> OUT_W = 2**IN_W one-hot output bits.
//  - One-cycle latency; en=0 clears the output rather than holding it.
//  - Reset is asynchronous, active-low.
// Optional feature macro: DECODER_ONEHOT_CHECK_EN
//  - When defined, adds a registered err output that flags a corrupted output
//    register (more than one bit set, or valid with no bit set).
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter  int IN_W  = DEC_IN_W_DEFAULT,
    localparam int OUT_W = dec_out_w(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [0:IN_W-1]  in,
    output logic [0:OUT_W-1] d,
    output logic             v
`ifdef DECODER_ONEHOT_CHECK_EN
    ,
    output logic             err
`endif
);

    logic [0:OUT_W-1] w_onehot;
    logic [0:OUT_W-1] r_d;
    logic             r_v;

    decoder_onehot_comb #(
        .IN_W     (IN_W)
    ) u_comb (
        .i_sel    (in),
        .o_onehot (w_onehot)
    );

    // Output register: capture the decode when enabled, otherwise clear.
    // An unknown en falls into the clear branch in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= '0;
            r_v <= 1'b0;
        end else if (en) begin
            r_d <= w_onehot;
            r_v <= 1'b1;
        end else begin
            r_d <= '0;
            r_v <= 1'b0;
        end
    end

    assign d = r_d;
    assign v = r_v;

    // A decode request with an unknown select produces an undefined output.
    a_in_known : assert property (@(posedge clk) disable iff (!rst_n)
        (en === 1'b1) |-> !$isunknown(in));

`ifdef DECODER_ONEHOT_CHECK_EN
    logic [OUT_W-1:0] w_d_vec;
    logic [OUT_W-1:0] w_d_minus1;
    logic             w_multi_hot;
    logic             w_err_next;
    logic             r_err;

    // x & (x-1) clears the lowest set bit; anything left means two or more bits set.
    assign w_d_vec     = r_d;
    assign w_d_minus1  = w_d_vec - OUT_W'(1);
    assign w_multi_hot = |(w_d_vec & w_d_minus1);
    assign w_err_next  = w_multi_hot | (r_v & ~(|w_d_vec));

    // Error flag register: reports the state of the output register one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4: default 2-bit instance and a 3-bit instance
// driven in lock-step. Expected results are queued when stimulus is applied and
// compared after the following clock edge.
module tb_decoder_2to4;
    import decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en4 = 1'b0;
    logic [0:1]  in4 = '0;
    dec_onehot_t d4;
    logic        v4;
    logic        en8 = 1'b0;
    logic [0:2]  in8 = '0;
    logic [0:7]  d8;
    logic        v8;
`ifdef DECODER_ONEHOT_CHECK_EN
    logic        err4;
    logic        err8;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [0:3] d4;
        logic       v4;
        logic [0:7] d8;
        logic       v8;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    decoder_2to4 dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en4),
        .in    (in4),
        .d     (d4),
        .v     (v4)
`ifdef DECODER_ONEHOT_CHECK_EN
        ,
        .err   (err4)
`endif
    );

    decoder_2to4 #(.IN_W(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en8),
        .in    (in8),
        .d     (d8),
        .v     (v8)
`ifdef DECODER_ONEHOT_CHECK_EN
        ,
        .err   (err8)
`endif
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus on both instances, queue the expectation,
    // then compare just after the capturing edge.
    task automatic step(input bit e, input int sel4, input int sel8, input string tag);
        exp_t       x;
        logic [0:3] m4;
        logic [0:7] m8;
        @(negedge clk);
        en4 = e;
        in4 = 2'(sel4);
        en8 = e;
        in8 = 3'(sel8);
        m4 = 4'b1000;
        m8 = 8'b1000_0000;
        x.d4 = e ? (m4 >> sel4) : 4'b0000;
        x.v4 = e;
        x.d8 = e ? (m8 >> sel8) : 8'h00;
        x.v8 = e;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        chk({tag, ".d4"}, 32'(d4), 32'(x.d4));
        chk({tag, ".v4"}, 32'(v4), 32'(x.v4));
        chk({tag, ".d8"}, 32'(d8), 32'(x.d8));
        chk({tag, ".v8"}, 32'(v8), 32'(x.v8));
        chk({tag, ".hot4"}, 32'($countones(d4) <= 1), 32'(1));
        chk({tag, ".hot8"}, 32'($countones(d8) <= 1), 32'(1));
`ifdef DECODER_ONEHOT_CHECK_EN
        chk({tag, ".err4"}, 32'(err4), 32'(0));
        chk({tag, ".err8"}, 32'(err8), 32'(0));
`endif
        $display("step %s en=%0d in4=%0d in8=%0d d4=%b v4=%0d d8=%b v8=%0d",
                 tag, e, sel4, sel8, d4, v4, d8, v8);
    endtask

    initial begin
        // Reset held with a pending decode request: outputs stay clear.
        rst_n = 1'b0;
        en4 = 1'b1; in4 = 2'd3; en8 = 1'b1; in8 = 3'd7;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst_hold.d4", 32'(d4), 32'(0));
            chk("rst_hold.v4", 32'(v4), 32'(0));
            chk("rst_hold.d8", 32'(d8), 32'(0));
            $display("reset cycle %0d d4=%b v4=%0d", c, d4, v4);
        end
        @(negedge clk);
        en4 = 1'b0; en8 = 1'b0;
        rst_n = 1'b1;

        // Sweep of every select value, back-to-back.
        for (int k = 0; k < 4; k++) step(1'b1, k, k, $sformatf("sweep%0d", k));
        for (int k = 4; k < 8; k++) step(1'b1, k % 4, k, $sformatf("sweep8_%0d", k));

        // Enable gating: no hold of the previous value.
        step(1'b1, 2, 5, "gate_on");
        step(1'b0, 1, 1, "gate_off");

        // Alternating extremes every cycle.
        for (int k = 0; k < 6; k++) step(1'b1, (k % 2) ? 3 : 0, (k % 2) ? 7 : 0, $sformatf("alt%0d", k));

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        step(1'b1, 1, 6, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.d4", 32'(d4), 32'(0));
        chk("async.v4", 32'(v4), 32'(0));
        chk("async.d8", 32'(d8), 32'(0));
        chk("async.v8", 32'(v8), 32'(0));
        $display("async reset d4=%b v4=%0d d8=%b v8=%0d", d4, v4, d8, v8);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1, 3, "post_rst");

        // A few random decodes.
        for (int k = 0; k < 8; k++) begin
            int r;
            r = int'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), r % 4, r, $sformatf("rnd%0d", k));
        end

`ifdef DECODER_ONEHOT_CHECK_EN
        // Corrupt the output register: error flag rises, then clears after release.
        step(1'b1, 2, 2, "pre_force");
        @(negedge clk);
        en4 = 1'b1; in4 = 2'd2;
        force dut4.r_d = 4'b0110;
        @(posedge clk);
        #1;
        chk("force.err4", 32'(err4), 32'(1));
        $display("force d4=%b err4=%0d", d4, err4);
        @(negedge clk);
        release dut4.r_d;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("release.err4", 32'(err4), 32'(0));
        chk("release.d4", 32'(d4), 32'(4'b0010));
        $display("release d4=%b err4=%0d", d4, err4);
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
